// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller.
// Accepts one access at a time from the pipeline, checks size/alignment,
// issues a single lane-aligned memory request, then returns the extended
// load data (or zero for stores and errors) with a one-cycle response pulse.
module lsu_align_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic [1:0]      rsp_err
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      waitCnt_q;
    logic            we_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [OW-1:0]   offset_q;
    logic            memReq_q;
    logic [AW-1:0]   memAddr_q;
    logic            memWe_q;
    logic [NB-1:0]   memBe_q;
    logic [DW-1:0]   memWdata_q;
    logic            rspValid_q;
    logic [DW-1:0]   rspRdata_q;
    logic [1:0]      rspErr_q;

    logic            accept;
    logic            isIllegal;
    logic            isMisaligned;
    logic [1:0]      checkErr;
    logic [OW-1:0]   reqOffset;
    logic [NB-1:0]   baseBe;
    logic [NB-1:0]   reqBe;
    logic [DW-1:0]   reqWdataSh;
    logic [AW-1:0]   reqAlignedAddr;
    logic            timeoutHit;
    logic [DW-1:0]   laneData;
    logic            laneMsb;
    int              laneBits;
    logic            fillBit;
    logic [DW-1:0]   loadData;

    // Ready is suppressed while reset is held so nothing is accepted during reset
    assign req_ready  = (state_q == IDLE) && reset;
    assign accept     = req_valid && req_ready;
    assign timeoutHit = (waitCnt_q == 8'(TIMEOUT - 1));

    assign mem_req   = memReq_q;
    assign mem_addr  = memAddr_q;
    assign mem_we    = memWe_q;
    assign mem_be    = memBe_q;
    assign mem_wdata = memWdata_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

    // Check the incoming request and precompute its lane-shifted memory view
    always_comb begin
        isIllegal    = (DW == 32) && (req_size == 2'd3);
        isMisaligned = 1'b0;
        case (req_size)
            2'd0:    isMisaligned = 1'b0;
            2'd1:    isMisaligned = req_addr[0];
            2'd2:    isMisaligned = (req_addr[1:0] != 2'b00);
            default: isMisaligned = (req_addr[2:0] != 3'b000);
        endcase
        if (isIllegal) begin
            checkErr = 2'd3;
        end else if (isMisaligned) begin
            checkErr = 2'd1;
        end else begin
            checkErr = 2'd0;
        end
        reqOffset = req_addr[OW-1:0];
        baseBe    = '0;
        case (req_size)
            2'd0:    baseBe[0]   = 1'b1;
            2'd1:    baseBe[1:0] = 2'b11;
            2'd2:    baseBe[3:0] = 4'b1111;
            default: baseBe      = '1;
        endcase
        reqBe          = baseBe << reqOffset;
        reqWdataSh     = req_wdata << {reqOffset, 3'b000};
        reqAlignedAddr = {req_addr[AW-1:OW], {OW{1'b0}}};
    end

    // Extract the addressed lane from the raw memory word and extend it
    always_comb begin
        laneData = mem_rdata >> {offset_q, 3'b000};
        case (size_q)
            2'd0: begin
                laneMsb  = laneData[7];
                laneBits = 8;
            end
            2'd1: begin
                laneMsb  = laneData[15];
                laneBits = 16;
            end
            2'd2: begin
                laneMsb  = laneData[31];
                laneBits = 32;
            end
            default: begin
                laneMsb  = laneData[DW-1];
                laneBits = DW;
            end
        endcase
        fillBit  = ~unsigned_q & laneMsb;
        loadData = laneData;
        for (int i = 0; i < DW; i++) begin
            if (i >= laneBits) begin
                loadData[i] = fillBit;
            end
        end
    end

    // Next-state logic for the access sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (checkErr != 2'd0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeoutHit) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, memory interface registers, wait counter and response
    always_ff @(posedge clk) begin
        if (!reset) begin
            waitCnt_q  <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            offset_q   <= '0;
            memReq_q   <= 1'b0;
            memAddr_q  <= '0;
            memWe_q    <= 1'b0;
            memBe_q    <= '0;
            memWdata_q <= '0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= '0;
        end else begin
            rspValid_q <= (state_d == RESP);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        offset_q   <= reqOffset;
                        if (checkErr != 2'd0) begin
                            rspErr_q   <= checkErr;
                            rspRdata_q <= '0;
                        end else begin
                            memReq_q   <= 1'b1;
                            memAddr_q  <= reqAlignedAddr;
                            memWe_q    <= req_we;
                            memBe_q    <= reqBe;
                            memWdata_q <= reqWdataSh;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        memReq_q  <= 1'b0;
                        waitCnt_q <= '0;
                    end
                end
                WAIT: begin
                    waitCnt_q <= waitCnt_q + 8'd1;
                    if (mem_rvalid) begin
                        rspErr_q   <= 2'd0;
                        rspRdata_q <= we_q ? '0 : loadData;
                    end else if (timeoutHit) begin
                        rspErr_q   <= 2'd2;
                        rspRdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Testbench for lsu_align_ctrl: a 32-bit and a 64-bit instance share the
// request and memory-side stimulus, each with its own req_valid.
module tb_lsu_align_ctrl;

    typedef struct packed {
        logic [1:0]  err;
        logic [63:0] rdata;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        reqValid32, reqValid64;
    logic        reqWe;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddr;
    logic [63:0] reqWdata;
    logic        memGnt;
    logic        memRvalid;
    logic [63:0] memRdata;

    logic        rdy32, memReq32, memWe32, rspValid32;
    logic [31:0] memAddr32, memWdata32, rspRdata32;
    logic [3:0]  memBe32;
    logic [1:0]  rspErr32;

    logic        rdy64, memReq64, memWe64, rspValid64;
    logic [31:0] memAddr64;
    logic [63:0] memWdata64, rspRdata64;
    logic [7:0]  memBe64;
    logic [1:0]  rspErr64;

    logic        sel;
    logic        obsReady, obsMemReq, obsMemWe, obsRspValid;
    logic [31:0] obsMemAddr;
    logic [7:0]  obsBe;
    logic [63:0] obsWdata, obsRdata;
    logic [1:0]  obsErr;

    int   testsRun;
    int   testsFailed;
    exp_t sbq[$];

    lsu_align_ctrl #(.DW(32), .AW(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid32), .req_ready(rdy32), .req_we(reqWe),
        .req_size(reqSize), .req_unsigned(reqUnsigned), .req_addr(reqAddr),
        .req_wdata(reqWdata[31:0]),
        .mem_req(memReq32), .mem_gnt(memGnt), .mem_addr(memAddr32),
        .mem_we(memWe32), .mem_be(memBe32), .mem_wdata(memWdata32),
        .mem_rvalid(memRvalid), .mem_rdata(memRdata[31:0]),
        .rsp_valid(rspValid32), .rsp_rdata(rspRdata32), .rsp_err(rspErr32)
    );

    lsu_align_ctrl #(.DW(64), .AW(32), .TIMEOUT(4)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid64), .req_ready(rdy64), .req_we(reqWe),
        .req_size(reqSize), .req_unsigned(reqUnsigned), .req_addr(reqAddr),
        .req_wdata(reqWdata),
        .mem_req(memReq64), .mem_gnt(memGnt), .mem_addr(memAddr64),
        .mem_we(memWe64), .mem_be(memBe64), .mem_wdata(memWdata64),
        .mem_rvalid(memRvalid), .mem_rdata(memRdata),
        .rsp_valid(rspValid64), .rsp_rdata(rspRdata64), .rsp_err(rspErr64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance onto one set of observation signals
    always_comb begin
        if (sel) begin
            obsReady    = rdy64;
            obsMemReq   = memReq64;
            obsMemWe    = memWe64;
            obsRspValid = rspValid64;
            obsMemAddr  = memAddr64;
            obsBe       = memBe64;
            obsWdata    = memWdata64;
            obsRdata    = rspRdata64;
            obsErr      = rspErr64;
        end else begin
            obsReady    = rdy32;
            obsMemReq   = memReq32;
            obsMemWe    = memWe32;
            obsRspValid = rspValid32;
            obsMemAddr  = memAddr32;
            obsBe       = {4'b0000, memBe32};
            obsWdata    = {32'h0, memWdata32};
            obsRdata    = {32'h0, rspRdata32};
            obsErr      = rspErr32;
        end
    end

    // Reference load result built byte by byte
    function automatic logic [63:0] expLoad(input bit is64, input logic [63:0] raw,
                                            input int off, input int size, input bit uns);
        logic [63:0] r;
        int nb;
        int dwb;
        logic msb;
        r   = '0;
        nb  = 1 << size;
        dwb = is64 ? 64 : 32;
        for (int b = 0; b < nb; b++) r[8*b +: 8] = raw[8*(off+b) +: 8];
        msb = r[8*nb-1];
        for (int i = 8*nb; i < dwb; i++) r[i] = uns ? 1'b0 : msb;
        return r;
    endfunction

    // Drive one request for a single cycle; caller sits #1 after an edge
    task automatic applyStimulus(input bit s, input bit we, input logic [1:0] size,
                                 input bit uns, input logic [31:0] addr, input logic [63:0] wd);
        reqWe       = we;
        reqSize     = size;
        reqUnsigned = uns;
        reqAddr     = addr;
        reqWdata    = wd;
        if (s) reqValid64 = 1'b1;
        else   reqValid32 = 1'b1;
        @(posedge clk); #1;
        reqValid32 = 1'b0;
        reqValid64 = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid on the selected instance
    task automatic waitRsp(output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (obsRspValid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0;
        testsRun++;
        if (obsReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 0", obsReady); end
        testsRun++;
        if ({obsMemReq, obsMemWe, obsBe, obsMemAddr, obsWdata} !== '0) begin
            testsFailed++; $display("[TB] FAIL reset_mem: req=%b we=%b be=%h addr=%h wdata=%h expected all 0", obsMemReq, obsMemWe, obsBe, obsMemAddr, obsWdata);
        end
        testsRun++;
        if ({obsRspValid, obsErr, obsRdata} !== '0) begin
            testsFailed++; $display("[TB] FAIL reset_rsp: valid=%b err=%0d rdata=%h expected all 0", obsRspValid, obsErr, obsRdata);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        testsRun++;
        if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_release_ready: got %b%b expected 11", rdy32, rdy64); end
    endtask

    task automatic test_load_byte();
        exp_t e;
        sel = 1'b0; memGnt = 1'b0; memRvalid = 1'b0; memRdata = 64'h80AABBCC;
        e.err = 2'd0; e.rdata = 64'hFFFFFF80;
        sbq.push_back(e);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'h1003, 64'h0);
        testsRun++;
        if (obsMemReq !== 1'b1 || obsMemWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL lb_issue: req=%b we=%b expected 1 0", obsMemReq, obsMemWe); end
        testsRun++;
        if (obsMemAddr !== 32'h1000) begin testsFailed++; $display("[TB] FAIL lb_addr: got %h expected 00001000", obsMemAddr); end
        testsRun++;
        if (obsBe !== 8'b0000_1000) begin testsFailed++; $display("[TB] FAIL lb_be: got %b expected 00001000", obsBe); end
        memGnt = 1'b1;
        @(posedge clk); #1;
        memGnt = 1'b0;
        testsRun++;
        if (obsMemReq !== 1'b0 || obsRspValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL lb_wait: req=%b valid=%b expected 0 0", obsMemReq, obsRspValid); end
        memRvalid = 1'b1;
        @(posedge clk); #1;
        memRvalid = 1'b0;
        testsRun++;
        if (obsRspValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL lb_latency: valid=%b expected 1 at third cycle", obsRspValid); end
        e = sbq.pop_front();
        testsRun++;
        if (obsErr !== e.err || obsRdata !== e.rdata) begin
            testsFailed++; $display("[TB] FAIL lb_rsp: err=%0d rdata=%h expected err=%0d rdata=%h", obsErr, obsRdata, e.err, e.rdata);
        end
        @(posedge clk); #1;
        testsRun++;
        if (obsRspValid !== 1'b0 || obsReady !== 1'b1 || obsRdata !== e.rdata) begin
            testsFailed++; $display("[TB] FAIL lb_after: valid=%b ready=%b rdata=%h expected 0 1 %h", obsRspValid, obsReady, obsRdata, e.rdata);
        end
    endtask

    task automatic test_store_stall();
        exp_t e;
        bit   got;
        int   cyc;
        sel = 1'b0; memRdata = 64'hFFFFFFFF;
        e.err = 2'd0; e.rdata = 64'h0;
        sbq.push_back(e);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 64'h0000BEEF);
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (obsMemReq !== 1'b1 || obsMemWe !== 1'b1 || obsBe !== 8'b0000_1100 || obsWdata !== 64'hBEEF0000 || obsMemAddr !== 32'h2000) begin
                testsFailed++; $display("[TB] FAIL st_hold[%0d]: req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 00001100 beef0000 00002000", i, obsMemReq, obsMemWe, obsBe, obsWdata, obsMemAddr);
            end
            @(posedge clk); #1;
        end
        memGnt = 1'b1;
        @(posedge clk); #1;
        memGnt = 1'b0;
        memRvalid = 1'b1;
        @(posedge clk); #1;
        memRvalid = 1'b0;
        waitRsp(got, cyc);
        testsRun++;
        if (!got) begin testsFailed++; $display("[TB] FAIL st_rsp_timeout: got no rsp_valid expected one"); end
        e = sbq.pop_front();
        testsRun++;
        if (obsErr !== e.err || obsRdata !== e.rdata) begin
            testsFailed++; $display("[TB] FAIL st_rsp: err=%0d rdata=%h expected err=%0d rdata=%h", obsErr, obsRdata, e.err, e.rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_double();
        exp_t e;
        bit   got;
        int   cyc;
        sel = 1'b1; memRdata = 64'h8122334455667788;
        e.err = 2'd0; e.rdata = 64'h8122334455667788;
        sbq.push_back(e);
        applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 32'h8, 64'h0);
        testsRun++;
        if (obsBe !== 8'hFF || obsMemAddr !== 32'h8) begin testsFailed++; $display("[TB] FAIL dbl_be: be=%h addr=%h expected ff 00000008", obsBe, obsMemAddr); end
        memGnt = 1'b1;
        @(posedge clk); #1;
        memGnt = 1'b0; memRvalid = 1'b1;
        @(posedge clk); #1;
        memRvalid = 1'b0;
        waitRsp(got, cyc);
        e = sbq.pop_front();
        testsRun++;
        if (!got || obsErr !== e.err || obsRdata !== e.rdata) begin
            testsFailed++; $display("[TB] FAIL dbl_rsp: got=%b err=%0d rdata=%h expected 1 err=%0d rdata=%h", got, obsErr, obsRdata, e.err, e.rdata);
        end
        @(posedge clk); #1;
        sel = 1'b0;
        e.err = 2'd3; e.rdata = 64'h0;
        sbq.push_back(e);
        applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 32'h8, 64'h0);
        e = sbq.pop_front();
        testsRun++;
        if (obsRspValid !== 1'b1 || obsMemReq !== 1'b0 || obsErr !== e.err || obsRdata !== e.rdata) begin
            testsFailed++; $display("[TB] FAIL illegal_size: valid=%b req=%b err=%0d rdata=%h expected 1 0 err=%0d rdata=%h", obsRspValid, obsMemReq, obsErr, obsRdata, e.err, e.rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        exp_t e;
        sel = 1'b0;
        e.err = 2'd1; e.rdata = 64'h0;
        sbq.push_back(e);
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h1001, 64'h0);
        e = sbq.pop_front();
        testsRun++;
        if (obsRspValid !== 1'b1 || obsMemReq !== 1'b0 || obsErr !== e.err || obsRdata !== e.rdata) begin
            testsFailed++; $display("[TB] FAIL misaligned: valid=%b req=%b err=%0d rdata=%h expected 1 0 err=%0d rdata=%h", obsRspValid, obsMemReq, obsErr, obsRdata, e.err, e.rdata);
        end
        @(posedge clk); #1;
        testsRun++;
        if (obsMemReq !== 1'b0 || obsRspValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL misaligned_after: req=%b valid=%b expected 0 0", obsMemReq, obsRspValid); end
        e.err = 2'd3;
        sbq.push_back(e);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 32'h1001, 64'h0);
        e = sbq.pop_front();
        testsRun++;
        if (obsErr !== e.err || obsMemReq !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL err_priority: err=%0d req=%b expected err=%0d req=0", obsErr, obsMemReq, e.err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   got;
        int   cyc;
        sel = 1'b0; memRdata = 64'hDEADBEEF;
        e.err = 2'd2; e.rdata = 64'h0;
        sbq.push_back(e);
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 64'h0);
        memRvalid = 1'b1;
        @(posedge clk); #1;
        memRvalid = 1'b0; memGnt = 1'b1;
        @(posedge clk); #1;
        memGnt = 1'b0;
        waitRsp(got, cyc);
        testsRun++;
        if (!got || cyc != 4) begin testsFailed++; $display("[TB] FAIL timeout_cycles: got=%b cycles=%0d expected 1 4", got, cyc); end
        e = sbq.pop_front();
        testsRun++;
        if (obsErr !== e.err || obsRdata !== e.rdata) begin
            testsFailed++; $display("[TB] FAIL timeout_rsp: err=%0d rdata=%h expected err=%0d rdata=%h", obsErr, obsRdata, e.err, e.rdata);
        end
        @(posedge clk); #1;
        e.err = 2'd0; e.rdata = 64'hFFFFFFFFDEADBEEF & 64'hFFFFFFFF;
        sbq.push_back(e);
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 64'h0);
        memGnt = 1'b1;
        @(posedge clk); #1;
        memGnt = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        testsRun++;
        if (obsRspValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_early: valid=%b expected 0 in 4th wait cycle", obsRspValid); end
        memRvalid = 1'b1;
        @(posedge clk); #1;
        memRvalid = 1'b0;
        e = sbq.pop_front();
        testsRun++;
        if (obsRspValid !== 1'b1 || obsErr !== e.err || obsRdata !== e.rdata) begin
            testsFailed++; $display("[TB] FAIL rvalid_wins: valid=%b err=%0d rdata=%h expected 1 err=%0d rdata=%h", obsRspValid, obsErr, obsRdata, e.err, e.rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   got;
        int   cyc;
        logic [63:0] raw;
        logic [7:0]  expBe;
        bit   uns;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int size = 0; size <= (s == 1 ? 3 : 2); size++) begin
                for (int off = 0; off < (s == 1 ? 8 : 4); off += (1 << size)) begin
                    raw = {$urandom, $urandom};
                    uns = 1'($urandom_range(0, 1));
                    memRdata = raw;
                    e.err   = 2'd0;
                    e.rdata = expLoad(s == 1, raw, off, size, uns);
                    expBe   = 8'(((1 << (1 << size)) - 1) << off);
                    sbq.push_back(e);
                    applyStimulus(s[0], 1'b0, 2'(size), uns, 32'h300 + 32'(off), 64'h0);
                    testsRun++;
                    if (obsBe !== expBe || obsMemAddr !== (s == 1 ? 32'h300 : 32'h300 + 32'(off & 4))) begin
                        testsFailed++; $display("[TB] FAIL b2b_be s=%0d size=%0d off=%0d: be=%b addr=%h expected be=%b", s, size, off, obsBe, obsMemAddr, expBe);
                    end
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    memGnt = 1'b1;
                    @(posedge clk); #1;
                    memGnt = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    memRvalid = 1'b1;
                    @(posedge clk); #1;
                    memRvalid = 1'b0;
                    waitRsp(got, cyc);
                    e = sbq.pop_front();
                    testsRun++;
                    if (!got || obsErr !== e.err || obsRdata !== e.rdata) begin
                        testsFailed++; $display("[TB] FAIL b2b_rsp s=%0d size=%0d off=%0d uns=%0d: got=%b err=%0d rdata=%h expected err=%0d rdata=%h", s, size, off, uns, got, obsErr, obsRdata, e.err, e.rdata);
                    end
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int seen;
        sel = 1'b0; memRdata = 64'h12345678;
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h44, 64'hCAFEF00D);
        memGnt = 1'b1;
        @(posedge clk); #1;
        memGnt = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        testsRun++;
        if ({obsReady, obsMemReq, obsMemWe, obsBe, obsMemAddr, obsWdata, obsRspValid, obsErr, obsRdata} !== '0) begin
            testsFailed++; $display("[TB] FAIL rst_wait_outputs: ready=%b req=%b we=%b be=%h addr=%h wdata=%h valid=%b err=%0d rdata=%h expected all 0", obsReady, obsMemReq, obsMemWe, obsBe, obsMemAddr, obsWdata, obsRspValid, obsErr, obsRdata);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        testsRun++;
        if (obsReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_wait_ready: got %b expected 1", obsReady); end
        seen = 0;
        memRvalid = 1'b1;
        repeat (4) begin
            if (obsRspValid) seen++;
            @(posedge clk); #1;
        end
        memRvalid = 1'b0;
        testsRun++;
        if (seen != 0) begin testsFailed++; $display("[TB] FAIL rst_wait_no_rsp: saw %0d rsp_valid cycles expected 0", seen); end
    endtask

    // Guard against a stuck run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run every scenario in sequence, then summarise
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        sel         = 1'b0;
        reset       = 1'b0;
        reqValid32  = 1'b0;
        reqValid64  = 1'b0;
        reqWe       = 1'b0;
        reqSize     = 2'd0;
        reqUnsigned = 1'b0;
        reqAddr     = '0;
        reqWdata    = '0;
        memGnt      = 1'b0;
        memRvalid   = 1'b0;
        memRdata    = '0;
        test_reset();
        test_load_byte();
        test_store_stall();
        test_double();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lsu_align_ctrl.md
LSU_ALIGN_CTRL -- requirements
Module: lsu_align_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for mem_rvalid; legal range 1..255.
REQ-004 Ports, with direction, width and meaning; clk and reset come first:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-low: asserted when 0, sampled on the rising edge of clk.
- req_valid  in  1  pipeline access request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (DW=64 only).
- req_unsigned  in  1  zero-extend load result.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-justified.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepted request.
- mem_addr  out  AW  DW/8-aligned address.
- mem_we  out  1  memory write.
- mem_be  out  DW/8  byte enables.
- mem_wdata  out  DW  lane-shifted store data.
- mem_rvalid  in  1  read/write completion.
- mem_rdata  in  DW  raw memory word.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DW  aligned, extended load data.
- rsp_err  out  2  0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size.

Function
REQ-005 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-006 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready, and all req_* inputs are registered at acceptance.
REQ-007 On acceptance SHALL check the request: misaligned if the address is not a multiple of 2^req_size; illegal if req_size=3 and DW=32.
REQ-008 A request failing the check SHALL go IDLE->RESP with no mem_req, and rsp_err set to 1 or 3; illegal size takes priority over misaligned.
REQ-009 A request passing the check SHALL go IDLE->ISSUE.
REQ-010 In ISSUE the unit SHALL hold mem_req=1 and keep mem_addr, mem_we, mem_be and mem_wdata stable until mem_gnt=1, then go to WAIT.
REQ-011 mem_addr SHALL equal the registered address with its low log2(DW/8) bits cleared.
REQ-012 mem_be SHALL have 2^size consecutive ones starting at bit index (addr mod DW/8).
REQ-013 mem_wdata SHALL be the registered write data shifted left by 8*(addr mod DW/8).
REQ-014 For loads, mem_be SHALL be driven to the same pattern as for stores.
REQ-015 In WAIT a cycle counter SHALL start at 0 and increment each cycle; mem_rvalid=1 SHALL latch mem_rdata and go to RESP with rsp_err=0.
REQ-016 If the counter reaches TIMEOUT with no mem_rvalid, the unit SHALL go to RESP with rsp_err=2 and rsp_rdata=0.
REQ-017 If mem_rvalid and timeout occur in the same cycle, mem_rvalid SHALL win.
REQ-018 For a load, rsp_rdata SHALL be the selected lane shifted right by 8*(addr mod DW/8) and truncated to 8*2^size bits.
REQ-019 For a load, the upper bits of rsp_rdata SHALL be sign-extended from the lane MSB when req_unsigned=0 and zero-filled otherwise; size equal to DW ignores req_unsigned.
REQ-020 For stores and error responses, rsp_rdata SHALL be 0.
REQ-021 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE.
REQ-022 Outside RESP, rsp_valid SHALL be 0 and rsp_rdata and rsp_err SHALL hold their last values.
REQ-023 Minimum latency SHALL be 3 cycles from acceptance to rsp_valid, with mem_gnt and mem_rvalid each in their first cycle; an error response SHALL take 1 cycle.
REQ-024 mem_rvalid arriving outside WAIT SHALL be ignored.

Reset
REQ-025 While reset=0 at a clock edge, the unit SHALL enter IDLE and clear the counter, mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_rdata and rsp_err to 0, with req_ready=0 during reset.
REQ-026 Reset in ISSUE or WAIT SHALL abandon the access without generating rsp_valid.
REQ-027 req_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-028 DW=32, load, addr=0x1003, size=0, unsigned=0, mem_rdata=0x80AABBCC -> mem_addr=0x1000, mem_be=1000b, rsp_rdata=0xFFFFFF80, rsp_err=0.
REQ-029 DW=32, store, addr=0x2002, size=1, wdata=0x0000BEEF -> mem_be=1100b, mem_wdata=0xBEEF0000, mem_req held through 3 cycles of mem_gnt=0, then rsp_valid with rsp_rdata=0.
REQ-030 DW=64, load, addr=0x8, size=3 -> mem_be=0xFF, rsp_rdata equals mem_rdata; and DW=32 with size=3 -> rsp_err=3 one cycle after acceptance, no mem_req.
REQ-031 Load, addr=0x1001, size=2 -> rsp_err=1, mem_req never asserted.
REQ-032 TIMEOUT=4 with no mem_rvalid -> rsp_err=2 after 4 WAIT cycles; a second run with mem_rvalid in the 4th WAIT cycle -> rsp_err=0.
REQ-033 reset=0 asserted in WAIT -> no rsp_valid, all outputs 0, req_ready=1 one cycle after reset is released.
